// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared constants, bank index type and counter width helper for the MCU collector
package mcu_pkg;

  localparam int MCU_DATA_W = 8;
  localparam int MCU_BLK    = 8;

  typedef logic bank_idx_t;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mcu_line_bank.sv
// rtl/mcu_line_bank.sv - one BLK-line bank of BLK-pixel words; element read only with MCU_TRANSPOSE_EN
module mcu_line_bank
  import mcu_pkg::*;
#(
  parameter int DATA_W = MCU_DATA_W,
  parameter int BLK    = MCU_BLK,
  parameter int WPL    = 8,
  localparam int LW    = cnt_w(BLK),
  localparam int CW    = cnt_w(WPL)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [LW-1:0]                wr_line,
  input  logic [CW-1:0]                wr_word,
  input  logic [BLK-1:0][DATA_W-1:0]   wr_data,
  input  logic [LW-1:0]                rd_line,
  input  logic [CW-1:0]                rd_word,
  output logic [BLK-1:0][DATA_W-1:0]   rd_data
`ifdef MCU_TRANSPOSE_EN
  ,
  input  logic [LW-1:0]                rd_elem,
  output logic [BLK-1:0][DATA_W-1:0]   col_data
`endif
);

  logic [BLK-1:0][DATA_W-1:0] mem_q [BLK][WPL];

  // Word write; the array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_line][wr_word] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_line][rd_word];

`ifdef MCU_TRANSPOSE_EN
  // Column gather: element rd_elem of word rd_word taken from every line.
  always_comb begin
    col_data = '0;
    for (int i = 0; i < BLK; i++) begin
      col_data[i] = mem_q[i][rd_word][rd_elem];
    end
  end
`endif

endmodule

// File: rtl/mcu_raster_to_block.sv
// rtl/mcu_raster_to_block.sv - raster stream to BLKxBLK MCU rows, ping-pong banks; MCU_TRANSPOSE_EN adds col_mode
module mcu_raster_to_block
  import mcu_pkg::*;
#(
  parameter int DATA_W = MCU_DATA_W,
  parameter int BLK    = MCU_BLK,
  parameter int IMG_W  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            din,
  input  logic                         din_valid,
  output logic                         din_ready,
`ifdef MCU_TRANSPOSE_EN
  input  logic                         col_mode,
`endif
  output logic [BLK-1:0][DATA_W-1:0]   dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(BLK)-1:0]       dout_row,
  output logic                         dout_last
);

  localparam int WPL = IMG_W / BLK;
  localparam int LW  = cnt_w(BLK);
  localparam int CW  = cnt_w(WPL);

  if (BLK < 2 || (IMG_W % BLK) != 0) begin : g_param_check
    $error("mcu_raster_to_block: BLK must be >= 2 and IMG_W a multiple of BLK");
  end

  typedef logic [BLK-1:0][DATA_W-1:0] word_t;

  // Write side
  word_t         asm_q, asm_d, wr_data;
  logic [LW-1:0] wr_pix_q, wr_pix_d, wr_line_q, wr_line_d;
  logic [CW-1:0] wr_word_q, wr_word_d;
  bank_idx_t     wr_bank_q, wr_bank_d;
  logic          din_fire, wr_word_end, wr_line_end, wr_bank_end;
  logic [1:0]    wr_en;

  // Bank occupancy
  logic [1:0]    bank_full_q, bank_full_d;

  // Read side: issue pointer plus the registered output beat
  logic [LW-1:0] rd_row_q, rd_row_d;
  logic [CW-1:0] rd_word_q, rd_word_d;
  bank_idx_t     rd_bank_q, rd_bank_d;
  word_t         dout_q, dout_d, rd_data;
  logic          dout_valid_q, dout_valid_d;
  logic [LW-1:0] dout_row_q, dout_row_d;
  logic          dout_last_q, dout_last_d;
  logic          dout_final_q, dout_final_d;
  bank_idx_t     dout_bank_q, dout_bank_d;
  logic          out_load, rd_issue, rd_row_end, rd_word_end, out_release;
  word_t         row_data [2];

  // Input handshake, pixel assembly and write-side counters.
  always_comb begin
    din_ready   = !bank_full_q[wr_bank_q];
    din_fire    = din_valid && din_ready;
    wr_word_end = (wr_pix_q == LW'(BLK - 1));
    wr_line_end = wr_word_end && (wr_word_q == CW'(WPL - 1));
    wr_bank_end = wr_line_end && (wr_line_q == LW'(BLK - 1));
    wr_data     = {din, asm_q[BLK-1:1]};
    asm_d       = asm_q;
    wr_pix_d    = wr_pix_q;
    wr_word_d   = wr_word_q;
    wr_line_d   = wr_line_q;
    wr_bank_d   = wr_bank_q;
    wr_en       = '0;
    if (din_fire) begin
      asm_d = wr_data;
      if (wr_word_end) begin
        wr_en[wr_bank_q] = 1'b1;
        wr_pix_d = '0;
        if (wr_line_end) begin
          wr_word_d = '0;
          if (wr_bank_end) begin
            wr_line_d = '0;
            wr_bank_d = ~wr_bank_q;
          end else begin
            wr_line_d = wr_line_q + 1'b1;
          end
        end else begin
          wr_word_d = wr_word_q + 1'b1;
        end
      end else begin
        wr_pix_d = wr_pix_q + 1'b1;
      end
    end
  end

  // Issue the next beat whenever the output register is empty or being consumed;
  // the issue pointer moves to the other bank as soon as the last beat is issued.
  always_comb begin
    out_load     = !dout_valid_q || dout_ready;
    rd_issue     = out_load && bank_full_q[rd_bank_q];
    rd_row_end   = (rd_row_q == LW'(BLK - 1));
    rd_word_end  = (rd_word_q == CW'(WPL - 1));
    out_release  = dout_valid_q && dout_ready && dout_final_q;
    rd_row_d     = rd_row_q;
    rd_word_d    = rd_word_q;
    rd_bank_d    = rd_bank_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_row_d   = dout_row_q;
    dout_last_d  = dout_last_q;
    dout_final_d = dout_final_q;
    dout_bank_d  = dout_bank_q;
    if (rd_issue) begin
      dout_d       = rd_data;
      dout_valid_d = 1'b1;
      dout_row_d   = rd_row_q;
      dout_last_d  = rd_row_end;
      dout_final_d = rd_row_end && rd_word_end;
      dout_bank_d  = rd_bank_q;
      if (rd_row_end) begin
        rd_row_d = '0;
        if (rd_word_end) begin
          rd_word_d = '0;
          rd_bank_d = ~rd_bank_q;
        end else begin
          rd_word_d = rd_word_q + 1'b1;
        end
      end else begin
        rd_row_d = rd_row_q + 1'b1;
      end
    end else if (out_load) begin
      dout_valid_d = 1'b0;
    end
  end

  // Bank occupancy: filled by the write side, freed when its final beat is accepted.
  always_comb begin
    bank_full_d = bank_full_q;
    if (din_fire && wr_bank_end) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
    if (out_release) begin
      bank_full_d[dout_bank_q] = 1'b0;
    end
  end

`ifdef MCU_TRANSPOSE_EN
  word_t col_data [2];
  logic  col_mode_q, col_mode_d, use_col;

  // Orientation is taken from col_mode on a block's first beat and held for its remaining beats.
  always_comb begin
    use_col    = (rd_row_q == '0) ? col_mode : col_mode_q;
    col_mode_d = col_mode_q;
    if (rd_issue && rd_row_q == '0) begin
      col_mode_d = col_mode;
    end
    rd_data = use_col ? col_data[rd_bank_q] : row_data[rd_bank_q];
  end

  // Per-block orientation register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_mode_q <= 1'b0;
    end else begin
      col_mode_q <= col_mode_d;
    end
  end
`else
  assign rd_data = row_data[rd_bank_q];
`endif

  // Control and output state; storage lives in the banks and is not reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q        <= '0;
      wr_pix_q     <= '0;
      wr_word_q    <= '0;
      wr_line_q    <= '0;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      rd_row_q     <= '0;
      rd_word_q    <= '0;
      rd_bank_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_row_q   <= '0;
      dout_last_q  <= 1'b0;
      dout_final_q <= 1'b0;
      dout_bank_q  <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      wr_pix_q     <= wr_pix_d;
      wr_word_q    <= wr_word_d;
      wr_line_q    <= wr_line_d;
      wr_bank_q    <= wr_bank_d;
      bank_full_q  <= bank_full_d;
      rd_row_q     <= rd_row_d;
      rd_word_q    <= rd_word_d;
      rd_bank_q    <= rd_bank_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_row_q   <= dout_row_d;
      dout_last_q  <= dout_last_d;
      dout_final_q <= dout_final_d;
      dout_bank_q  <= dout_bank_d;
    end
  end

  mcu_line_bank #(.DATA_W(DATA_W), .BLK(BLK), .WPL(WPL)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en[0]),
    .wr_line (wr_line_q),
    .wr_word (wr_word_q),
    .wr_data (wr_data),
    .rd_line (rd_row_q),
    .rd_word (rd_word_q),
    .rd_data (row_data[0])
`ifdef MCU_TRANSPOSE_EN
    ,
    .rd_elem (rd_row_q),
    .col_data(col_data[0])
`endif
  );

  mcu_line_bank #(.DATA_W(DATA_W), .BLK(BLK), .WPL(WPL)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_en[1]),
    .wr_line (wr_line_q),
    .wr_word (wr_word_q),
    .wr_data (wr_data),
    .rd_line (rd_row_q),
    .rd_word (rd_word_q),
    .rd_data (row_data[1])
`ifdef MCU_TRANSPOSE_EN
    ,
    .rd_elem (rd_row_q),
    .col_data(col_data[1])
`endif
  );

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_row   = dout_row_q;
  assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_mcu_raster_to_block.sv
// tb/tb_mcu_raster_to_block.sv - directed self-checking bench for mcu_raster_to_block (IMG_W=16, BLK=8)
module tb_mcu_raster_to_block;

  localparam int DATA_W = 8;
  localparam int BLK    = 8;
  localparam int IMG_W  = 16;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [DATA_W-1:0]          din = '0;
  logic                       din_valid = 1'b0;
  logic                       din_ready;
  logic [BLK-1:0][DATA_W-1:0] dout;
  logic                       dout_valid;
  logic                       dout_ready = 1'b0;
  logic [2:0]                 dout_row;
  logic                       dout_last;
`ifdef MCU_TRANSPOSE_EN
  logic                       col_mode = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, next_pix, pix_limit, first_valid, px127_cyc;
  logic [63:0] bq [$];
  logic [2:0]  rq [$];
  logic        lq [$];
  int          cq [$];

  always #5 clk = ~clk;

  mcu_raster_to_block #(.DATA_W(DATA_W), .BLK(BLK), .IMG_W(IMG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
`ifdef MCU_TRANSPOSE_EN
    .col_mode  (col_mode),
`endif
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_row  (dout_row),
    .dout_last (dout_last)
  );

  // Row-major expectation for the b-th beat of a ramp: 128 pixels per bank.
  function automatic logic [63:0] exp_row(input int b);
    logic [63:0] e;
    int k, bb, bx, r;
    k  = b / 16;
    bb = b % 16;
    bx = bb / 8;
    r  = bb % 8;
    for (int i = 0; i < 8; i++) e[i*8 +: 8] = 8'((k * 128 + r * 16 + bx * 8 + i) % 256);
    return e;
  endfunction

  // Record the transfers the coming posedge will perform, then advance to the next negedge.
  task automatic step();
    if (dout_valid && first_valid < 0) first_valid = cyc;
    if (dout_valid && dout_ready) begin
      bq.push_back(dout);
      rq.push_back(dout_row);
      lq.push_back(dout_last);
      cq.push_back(cyc);
    end
    if (din_valid && din_ready) begin
      if (next_pix == 127) px127_cyc = cyc;
      next_pix++;
    end
    @(negedge clk);
    cyc++;
    din       = 8'(next_pix % 256);
    din_valid = (next_pix < pix_limit);
  endtask

  task automatic start(input int limit);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bq.delete(); rq.delete(); lq.delete(); cq.delete();
    cyc = 0; next_pix = 0; pix_limit = limit; first_valid = -1; px127_cyc = -1;
    din = '0;
    din_valid = (limit > 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    #1;
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got %b want 0", dout_valid); end
    n_checks++; if (dout !== 64'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
    n_checks++; if (dout_row !== 3'd0) begin n_fail++; $display("FAIL reset_dout_row got %0d want 0", dout_row); end
    n_checks++; if (dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_dout_last got %b want 0", dout_last); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start(128);
    for (int t = 0; t < 400 && bq.size() < 16; t++) step();
    for (int t = 0; t < 20; t++) step();
    n_checks++; if (bq.size() != 16) begin n_fail++; $display("FAIL basic_beat_count got %0d want 16", bq.size()); end
    for (int b = 0; b < 16 && b < bq.size(); b++) begin
      n_checks++; if (bq[b] !== exp_row(b)) begin n_fail++; $display("FAIL basic_data beat %0d got %h want %h", b, bq[b], exp_row(b)); end
      n_checks++; if (rq[b] !== 3'(b % 8)) begin n_fail++; $display("FAIL basic_row beat %0d got %0d want %0d", b, rq[b], b % 8); end
      n_checks++; if (lq[b] !== (b % 8 == 7)) begin n_fail++; $display("FAIL basic_last beat %0d got %b want %b", b, lq[b], (b % 8 == 7)); end
    end
    n_checks++; if (first_valid != px127_cyc + 2 || px127_cyc < 0) begin
      n_fail++; $display("FAIL basic_latency first_valid cycle %0d want %0d", first_valid, px127_cyc + 2);
    end
  endtask

  task automatic test_backpressure();
    int stall;
    stall = 0;
    start(128);
    for (int t = 0; t < 400 && bq.size() < 16; t++) begin
      if (bq.size() == 3 && dout_valid && stall < 5) begin
        dout_ready = 1'b0;
        n_checks++; if (dout !== exp_row(3)) begin n_fail++; $display("FAIL bp_hold_data stall %0d got %h want %h", stall, dout, exp_row(3)); end
        n_checks++; if (dout_row !== 3'd3) begin n_fail++; $display("FAIL bp_hold_row stall %0d got %0d want 3", stall, dout_row); end
        stall++;
      end else begin
        dout_ready = 1'b1;
      end
      step();
    end
    for (int t = 0; t < 20; t++) step();
    n_checks++; if (stall != 5) begin n_fail++; $display("FAIL bp_stall_cycles got %0d want 5", stall); end
    n_checks++; if (bq.size() != 16) begin n_fail++; $display("FAIL bp_beat_count got %0d want 16", bq.size()); end
    for (int b = 0; b < 16 && b < bq.size(); b++) begin
      n_checks++; if (bq[b] !== exp_row(b)) begin n_fail++; $display("FAIL bp_data beat %0d got %h want %h", b, bq[b], exp_row(b)); end
    end
  endtask

  task automatic test_full();
    start(384);
    dout_ready = 1'b0;
    for (int t = 0; t < 600 && din_ready; t++) step();
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_fall got %b want 0", din_ready); end
    n_checks++; if (next_pix != 256) begin n_fail++; $display("FAIL full_accepted got %0d want 256", next_pix); end
    for (int t = 0; t < 4; t++) step();
    n_checks++; if (din_ready !== 1'b0 || next_pix != 256) begin
      n_fail++; $display("FAIL full_hold din_ready %b accepted %0d want 0/256", din_ready, next_pix);
    end
    n_checks++; if (dout_valid !== 1'b1 || dout !== exp_row(0)) begin
      n_fail++; $display("FAIL full_hold_out valid %b data %h want 1/%h", dout_valid, dout, exp_row(0));
    end
    dout_ready = 1'b1;
    for (int t = 0; t < 100 && bq.size() < 16; t++) begin
      if (bq.size() == 15 && dout_valid) begin
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_at_last got %b want 0", din_ready); end
      end
      step();
    end
    n_checks++; if (din_ready !== 1'b1 || bq.size() != 16) begin
      n_fail++; $display("FAIL full_ready_return din_ready %b beats %0d want 1/16", din_ready, bq.size());
    end
    n_checks++; if (next_pix != 256) begin n_fail++; $display("FAIL full_no_early_px got %0d want 256", next_pix); end
    for (int t = 0; t < 800 && bq.size() < 48; t++) step();
    n_checks++; if (bq.size() != 48) begin n_fail++; $display("FAIL full_beat_count got %0d want 48", bq.size()); end
    if (bq.size() >= 48) begin
      n_checks++; if (cq[16] != cq[15] + 1) begin n_fail++; $display("FAIL full_bank_bubble cycle %0d want %0d", cq[16], cq[15] + 1); end
      for (int b = 16; b < 48; b++) begin
        n_checks++; if (bq[b] !== exp_row(b)) begin n_fail++; $display("FAIL full_data beat %0d got %h want %h", b, bq[b], exp_row(b)); end
      end
    end
  endtask

  task automatic test_stream();
    int stalled, gaps;
    stalled = 0;
    gaps = 0;
    start(512);
    for (int t = 0; t < 1200 && bq.size() < 64; t++) begin
      if (din_valid && !din_ready) stalled++;
      step();
    end
    n_checks++; if (bq.size() != 64) begin n_fail++; $display("FAIL stream_beat_count got %0d want 64", bq.size()); end
    n_checks++; if (stalled != 0) begin n_fail++; $display("FAIL stream_input_stall got %0d want 0", stalled); end
    for (int b = 0; b < 64 && b < bq.size(); b++) begin
      if (b % 16 != 0 && cq[b] != cq[b-1] + 1) gaps++;
      n_checks++; if (bq[b] !== exp_row(b)) begin n_fail++; $display("FAIL stream_data beat %0d got %h want %h", b, bq[b], exp_row(b)); end
    end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps got %0d want 0", gaps); end
  endtask

  task automatic test_reset_mid();
    start(128);
    for (int t = 0; t < 200 && next_pix < 61; t++) step();
    rst = 1'b1;
    #1;
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dout_valid got %b want 0", dout_valid); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_din_ready got %b want 1", din_ready); end
    start(128);
    for (int t = 0; t < 400 && bq.size() < 16; t++) step();
    n_checks++; if (bq.size() != 16) begin n_fail++; $display("FAIL rstmid_beat_count got %0d want 16", bq.size()); end
    for (int b = 0; b < 16 && b < bq.size(); b++) begin
      n_checks++; if (bq[b] !== exp_row(b)) begin n_fail++; $display("FAIL rstmid_data beat %0d got %h want %h", b, bq[b], exp_row(b)); end
    end
  endtask

`ifdef MCU_TRANSPOSE_EN
  task automatic test_transpose();
    logic [63:0] e;
    start(128);
    for (int t = 0; t < 400 && bq.size() < 16; t++) begin
      col_mode = (bq.size() < 3);
      step();
    end
    col_mode = 1'b0;
    n_checks++; if (bq.size() != 16) begin n_fail++; $display("FAIL tr_beat_count got %0d want 16", bq.size()); end
    for (int b = 0; b < 16 && b < bq.size(); b++) begin
      if (b < 8) begin
        for (int i = 0; i < 8; i++) e[i*8 +: 8] = 8'(i * 16 + b);
      end else begin
        e = exp_row(b);
      end
      n_checks++; if (bq[b] !== e) begin n_fail++; $display("FAIL tr_data beat %0d got %h want %h", b, bq[b], e); end
      n_checks++; if (rq[b] !== 3'(b % 8)) begin n_fail++; $display("FAIL tr_row beat %0d got %0d want %0d", b, rq[b], b % 8); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full();
    test_stream();
    test_reset_mid();
`ifdef MCU_TRANSPOSE_EN
    test_transpose();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_raster_to_block.md
Name: mcu_raster_to_block

Overview:
- Converts a raster-order pixel stream into BLK x BLK MCU blocks for the downstream DCT stage.
- Outputs one block row, BLK pixels wide, per beat.
- Generalises the fixed 8x8 MCU collector:
  - parametrised pixel width, block size and line width;
  - ping-pong line banks, so input and output overlap;
  - valid/ready backpressure on both sides.

Parameters:
- DATA_W, 8: bits per pixel.
- BLK, 8: block edge in pixels. Must be >= 2.
- IMG_W, 64: pixels per image line. Must be a multiple of BLK; elaboration-time assertion.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  DATA_W  raster pixel.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept din this cycle.
- dout  out  [BLK-1:0][DATA_W]  one block row; dout[0] is the leftmost pixel.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  downstream accepts dout.
- dout_row  out  $clog2(BLK)  row index within the current block.
- dout_last  out  1  final row of the current block.

Behaviour:
- Reset (async assert, sync release): write/read counters = 0, wr_bank = rd_bank = 0, bank_full = 2'b00.
  - Outputs at reset: dout_valid=0, dout='0, dout_row=0, dout_last=0, din_ready=1.
  - Storage array is not reset.
  - Reset mid-operation discards all buffered pixels and any partially accepted block.
- Storage:
  - 2 banks, each BLK lines x (IMG_W/BLK) words; a word holds BLK pixels.
  - Input pixels shift into a BLK-pixel assembly register.
  - On the BLK-th pixel, the word is written at {wr_bank, wr_line, wr_col/BLK}.
- Input handshake:
  - Transfer when din_valid && din_ready.
  - din_ready = !bank_full[wr_bank]. It is combinational from state only, never from din_valid.
  - wr_col wraps at IMG_W-1 and increments wr_line.
  - On the final pixel of wr_line==BLK-1: set bank_full[wr_bank] and toggle wr_bank at the same edge.
- Output sequencing:
  - When bank_full[rd_bank], emit IMG_W beats: for bx = 0..IMG_W/BLK-1, for r = 0..BLK-1, dout = word[rd_bank][r][bx].
  - dout_row = r; dout_last = (r == BLK-1).
  - Outputs are registered. dout_valid rises one cycle after the edge that set bank_full.
  - While dout_valid && !dout_ready, dout, dout_row and dout_last hold stable.
  - With dout_ready=1 the output sustains one beat per cycle, with no bubble between blocks or between banks when the next bank is already full.
  - When the final beat of a bank is accepted: clear bank_full[rd_bank] and toggle rd_bank.
- Simultaneous set (write side) and clear (read side) target different banks by construction; both take effect.
- Both banks full: din_ready=0 until the read side releases a bank. din_ready returns to 1 the cycle after the final beat is accepted.
- Throughput:
  - Input: 1 pixel/cycle.
  - Output: IMG_W beats drain a bank filled in BLK*IMG_W cycles, so the output never stalls input when dout_ready=1.

Optional Feature:
- Macro: MCU_TRANSPOSE_EN.
- Defined:
  - Adds input port col_mode (1 bit).
  - col_mode is sampled on the first beat of each block and held for that block.
  - col_mode=1: beat r carries column r of the block, i.e. dout[i] = pixel(line i, x = bx*BLK + r). dout_row then indicates the column index.
  - col_mode=0: row-major, as above.
- Undefined: no col_mode port; row-major only; no extra read multiplexing.

Decomposition:
- Package mcu_pkg:
  - default constants MCU_DATA_W=8, MCU_BLK=8;
  - typedef bank_idx_t (1 bit);
  - function clog2-safe width helper for row/column counters.
- One sub-module, mcu_line_bank:
  - a single bank's storage array;
  - write port: word, line, word index;
  - read port: row-read of one word, plus a per-line element read for transpose.
  - Instantiated twice.

Test Plan:
Parameters for all cases: IMG_W=16, BLK=8, DATA_W=8. Ramp input: pixel k = k mod 256, din_valid=1, dout_ready=1.
- Basic ordering:
  - Beat 0 = {0..7}, dout_row=0.
  - Beat 1 = {16..23}.
  - Beat 7 = {112..119}, dout_last=1.
  - Beat 8 = {8..15}, dout_row=0.
  - First dout_valid appears 1 cycle after pixel 127 is accepted.
- Backpressure: dout_ready=0 for 5 cycles at beat 3 -> dout stays {48..55} and dout_row stays 3 for all 5 cycles; no beat is lost or duplicated.
- Full: dout_ready held 0 -> din_ready falls after pixel 255 is accepted. Raise dout_ready -> din_ready returns 1 the cycle after beat 15 of bank 0 is accepted. Pixel 256 then lands in bank 0, and bank 1 output = {128..135} first.
- Continuous streaming: 4 banks back-to-back -> 64 consecutive output beats with no gap once output starts.
- Reset mid-fill: assert rst after pixel 60 -> dout_valid=0 and din_ready=1 immediately. Restart the ramp from 0 -> beat 0 = {0..7}.
- MCU_TRANSPOSE_EN with col_mode=1: beat 0 = {0,16,32,...,112}, beat 1 = {1,17,...,113}. col_mode toggled mid-block has no effect until the next block.
